// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its consumers.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Register 0 is hardwired to zero and can never be pending.
    localparam int unsigned ZERO_ADDR = 32'd0;

    // Where a read port takes its data from; also used by the hazard unit.
    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_BYP_W1 = 2'd1,
        SRC_BYP_W0 = 2'd2,
        SRC_STORED = 2'd3
    } rd_src_e;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: source select (zero / bypass / stored), data mux and ready flag.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_stored,
    input  logic              i_pending,
    input  logic              i_w0_en,
    input  logic [ADDR_W-1:0] i_w0_addr,
    input  logic [DATA_W-1:0] i_w0_data,
    input  logic              i_w1_en,
    input  logic [ADDR_W-1:0] i_w1_addr,
    input  logic [DATA_W-1:0] i_w1_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_rdy
);

    localparam logic BYP_ON = (BYPASS != 0);

    logic    w_is_zero;
    logic    w_hit_w1;
    logic    w_hit_w0;
    rd_src_e w_sel;

    assign w_is_zero = (i_addr == ADDR_W'(ZERO_ADDR));
    assign w_hit_w1  = BYP_ON && i_w1_en && (i_w1_addr == i_addr);
    assign w_hit_w0  = BYP_ON && i_w0_en && (i_w0_addr == i_addr);

    // Pick the read source; W1 beats W0 because W1 also wins the store.
    always_comb begin
        w_sel = SRC_STORED;
        if (w_is_zero) begin
            w_sel = SRC_ZERO;
        end else if (w_hit_w1) begin
            w_sel = SRC_BYP_W1;
        end else if (w_hit_w0) begin
            w_sel = SRC_BYP_W0;
        end else begin
            w_sel = SRC_STORED;
        end
    end

    // Data mux driven by the source select.
    always_comb begin
        o_data = '0;
        case (w_sel)
            SRC_ZERO:   o_data = '0;
            SRC_BYP_W1: o_data = i_w1_data;
            SRC_BYP_W0: o_data = i_w0_data;
            SRC_STORED: o_data = i_stored;
            default:    o_data = '0;
        endcase
    end

    // Operand is ready unless pending, or the pending load is landing right now.
    always_comb begin
        o_rdy = 1'b1;
        if (w_is_zero) begin
            o_rdy = 1'b1;
        end else begin
            o_rdy = !i_pending || w_hit_w1;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Two-write / two-read register file with per-register pending scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              W0_en,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic [DATA_W-1:0] W0_data,
    input  logic              W1_en,
    input  logic [ADDR_W-1:0] W1_addr,
    input  logic [DATA_W-1:0] W1_data,
    input  logic              RES_en,
    input  logic [ADDR_W-1:0] RES_addr,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busX,
    output logic [DATA_W-1:0] busY,
    output logic              X_rdy,
    output logic              Y_rdy,
    output logic              wr_conflict,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic              r_conflict;
    logic [ADDR_W:0]   r_pend_cnt;

    logic [DEPTH-1:0]  w_pend_next;
    logic [ADDR_W:0]   w_cnt_next;
    logic              w_conflict;

    assign w_conflict = W0_en && W1_en && (W0_addr == W1_addr) &&
                        (W1_addr != ADDR_W'(ZERO_ADDR));

    // Next pending vector: a new reservation wins over a same-cycle W1 clear.
    always_comb begin
        w_pend_next = r_pend;
        for (int i = 1; i < DEPTH; i++) begin
            if (RES_en && (RES_addr == ADDR_W'(i))) begin
                w_pend_next[i] = 1'b1;
            end else if (W1_en && (W1_addr == ADDR_W'(i))) begin
                w_pend_next[i] = 1'b0;
            end else begin
                w_pend_next[i] = r_pend[i];
            end
        end
        w_pend_next[0] = 1'b0;
    end

    // Popcount of the next pending vector so the count tracks the visible bits.
    always_comb begin
        w_cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_next = w_cnt_next + {{ADDR_W{1'b0}}, w_pend_next[i]};
        end
    end

    // Storage, scoreboard, conflict pulse and counter; sync active-low reset.
    always_ff @(posedge Clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend     <= '0;
            r_conflict <= 1'b0;
            r_pend_cnt <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (W1_en && (W1_addr == ADDR_W'(i))) begin
                    r_mem[i] <= W1_data;
                end else if (W0_en && (W0_addr == ADDR_W'(i))) begin
                    r_mem[i] <= W0_data;
                end
            end
            r_mem[0]   <= '0;
            r_pend     <= w_pend_next;
            r_conflict <= w_conflict;
            r_pend_cnt <= w_cnt_next;
        end
    end

    assign wr_conflict = r_conflict;
    assign pend_cnt    = r_pend_cnt;

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_x (
        .i_addr    (RX),
        .i_stored  (r_mem[RX]),
        .i_pending (r_pend[RX]),
        .i_w0_en   (W0_en),
        .i_w0_addr (W0_addr),
        .i_w0_data (W0_data),
        .i_w1_en   (W1_en),
        .i_w1_addr (W1_addr),
        .i_w1_data (W1_data),
        .o_data    (busX),
        .o_rdy     (X_rdy)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port_y (
        .i_addr    (RY),
        .i_stored  (r_mem[RY]),
        .i_pending (r_pend[RY]),
        .i_w0_en   (W0_en),
        .i_w0_addr (W0_addr),
        .i_w0_data (W0_data),
        .i_w1_en   (W1_en),
        .i_w1_addr (W1_addr),
        .i_w1_data (W1_data),
        .o_data    (busY),
        .o_rdy     (Y_rdy)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench: bypass and non-bypass builds side by side against a behavioural model.
module tb_regfile_mp_sb;

    logic        Clk = 1'b0;
    logic        rst;
    logic        W0_en, W1_en, RES_en;
    logic [4:0]  W0_addr, W1_addr, RES_addr, RX, RY;
    logic [31:0] W0_data, W1_data;

    logic [31:0] bx1, by1, bx0, by0;
    logic        xr1, yr1, xr0, yr0, cf1, cf0;
    logic [5:0]  pc1, pc0;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    // Model state: architectural contents and pending flags.
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_conf;
    int          m_cnt;

    always #5 Clk = ~Clk;

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b1 (
        .Clk(Clk), .rst(rst),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
        .W1_en(W1_en), .W1_addr(W1_addr), .W1_data(W1_data),
        .RES_en(RES_en), .RES_addr(RES_addr), .RX(RX), .RY(RY),
        .busX(bx1), .busY(by1), .X_rdy(xr1), .Y_rdy(yr1),
        .wr_conflict(cf1), .pend_cnt(pc1)
    );

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_b0 (
        .Clk(Clk), .rst(rst),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
        .W1_en(W1_en), .W1_addr(W1_addr), .W1_data(W1_data),
        .RES_en(RES_en), .RES_addr(RES_addr), .RX(RX), .RY(RY),
        .busX(bx0), .busY(by0), .X_rdy(xr0), .Y_rdy(yr0),
        .wr_conflict(cf0), .pend_cnt(pc0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && W1_en && W1_addr == a) return W1_data;
        if (byp && W0_en && W0_addr == a) return W0_data;
        return m_mem[a];
    endfunction

    function automatic logic ref_rdy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b1;
        return !m_pend[a] || (byp && W1_en && W1_addr == a);
    endfunction

    task automatic model_clock();
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'd0;
                m_pend[i] = 1'b0;
            end
            m_conf = 1'b0;
        end else begin
            m_conf = W0_en && W1_en && W0_addr == W1_addr && W1_addr != 5'd0;
            if (W0_en && W0_addr != 5'd0) m_mem[W0_addr] = W0_data;
            if (W1_en && W1_addr != 5'd0) m_mem[W1_addr] = W1_data;
            if (W1_en && W1_addr != 5'd0) m_pend[W1_addr] = 1'b0;
            if (RES_en && RES_addr != 5'd0) m_pend[RES_addr] = 1'b1;
        end
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_cnt += int'(m_pend[i]);
    endtask

    // Check combinational outputs mid-cycle, clock, then check registered outputs.
    task automatic cycle();
        #2;
        if (armed) begin
            check("busX_byp",    bx1, ref_read(RX, 1'b1));
            check("busY_byp",    by1, ref_read(RY, 1'b1));
            check("Xrdy_byp",    32'(xr1), 32'(ref_rdy(RX, 1'b1)));
            check("Yrdy_byp",    32'(yr1), 32'(ref_rdy(RY, 1'b1)));
            check("busX_nobyp",  bx0, ref_read(RX, 1'b0));
            check("busY_nobyp",  by0, ref_read(RY, 1'b0));
            check("Xrdy_nobyp",  32'(xr0), 32'(ref_rdy(RX, 1'b0)));
            check("Yrdy_nobyp",  32'(yr0), 32'(ref_rdy(RY, 1'b0)));
        end
        @(posedge Clk);
        model_clock();
        #1;
        if (!rst) armed = 1'b1;
        if (armed) begin
            check("conflict_byp",   32'(cf1), 32'(m_conf));
            check("conflict_nobyp", 32'(cf0), 32'(m_conf));
            check("pendcnt_byp",    32'(pc1), 32'(m_cnt));
            check("pendcnt_nobyp",  32'(pc0), 32'(m_cnt));
        end
    endtask

    task automatic idle();
        rst = 1'b1; W0_en = 1'b0; W1_en = 1'b0; RES_en = 1'b0;
        W0_addr = 5'd0; W1_addr = 5'd0; RES_addr = 5'd0;
        W0_data = 32'd0; W1_data = 32'd0;
    endtask

    initial begin
        idle();
        RX = 5'd0; RY = 5'd0;
        for (int i = 0; i < 32; i++) begin m_mem[i] = 32'd0; m_pend[i] = 1'b0; end
        m_conf = 1'b0; m_cnt = 0;
        @(posedge Clk); #1;

        // Reset, then reset discards an earlier write.
        rst = 1'b0; cycle(); cycle();
        idle(); W0_en = 1'b1; W0_addr = 5'd5; W0_data = 32'hA5A5A5A5; RX = 5'd5; cycle();
        idle(); rst = 1'b0; cycle();
        idle(); cycle();
        check("reset_busX", bx1, 32'd0);

        // Collision on r7: W1 data kept, one-cycle conflict pulse.
        idle(); W0_en = 1'b1; W0_addr = 5'd7; W0_data = 32'h11;
        W1_en = 1'b1; W1_addr = 5'd7; W1_data = 32'h22; RX = 5'd7;
        #2; check("coll_bypass_busX", bx1, 32'h22); #(-0);
        cycle();
        check("coll_pulse", 32'(cf1), 32'd1);
        idle(); cycle();
        check("coll_stored", bx0, 32'h22);
        check("coll_pulse_end", 32'(cf1), 32'd0);

        // Register 0 ignores writes and reserves.
        idle(); W0_en = 1'b1; W0_addr = 5'd0; W0_data = 32'hFFFFFFFF;
        RES_en = 1'b1; RES_addr = 5'd0; RX = 5'd0; cycle();
        idle(); cycle();

        // Scoreboard: reserve r3, then load writeback.
        idle(); RES_en = 1'b1; RES_addr = 5'd3; RY = 5'd3; cycle();
        check("res_cnt", 32'(pc1), 32'd1);
        idle(); W1_en = 1'b1; W1_addr = 5'd3; W1_data = 32'h1234; cycle();
        idle(); cycle();
        check("res_clear_cnt", 32'(pc1), 32'd0);

        // Simultaneous reserve and writeback on r4.
        idle(); RES_en = 1'b1; RES_addr = 5'd4; RX = 5'd4; cycle();
        idle(); RES_en = 1'b1; RES_addr = 5'd4; W1_en = 1'b1; W1_addr = 5'd4; W1_data = 32'h55; cycle();
        idle(); cycle();
        check("resw1_data", bx0, 32'h55);
        check("resw1_pend", 32'(xr1), 32'd0);

        // Bypass-less read shows old value during the write cycle.
        idle(); W0_en = 1'b1; W0_addr = 5'd9; W0_data = 32'h99; RX = 5'd9; cycle();
        idle(); cycle();

        // Randomised traffic, addresses biased to a small range for collisions.
        for (int n = 0; n < 600; n++) begin
            idle();
            rst      = ($urandom_range(0, 60) != 0);
            W0_en    = 1'($urandom);
            W1_en    = 1'($urandom);
            RES_en   = ($urandom_range(0, 3) == 0);
            W0_addr  = 5'($urandom_range(0, 7));
            W1_addr  = 5'($urandom_range(0, 7));
            RES_addr = 5'($urandom_range(0, 7));
            RX       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            RY       = 5'($urandom_range(0, 7));
            W0_data  = $urandom;
            W1_data  = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
